// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: FSM state encodings.
package ram_fifo_ctrl_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-port synchronous RAM (1-cycle read latency) with one output register.
// Optional watermark output max_level is enabled by defining RAM_FIFO_WATERMARK_EN.
//
// state      | meaning
// ST_IDLE    | port free; a read is issued whenever the RAM holds words and the output slot can take one
// ST_RD_WAIT | read in flight; RAM data_out is captured into rd_data this cycle, port free for a write
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [DEPTH+1:0] level,
  output logic             ram_enable,
  output logic             ram_wr_en,
  output logic [DEPTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out
`ifdef RAM_FIFO_WATERMARK_EN
  ,
  output logic [DEPTH+1:0] max_level
`endif
);

  localparam logic [DEPTH:0]   MEM_FULL  = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0]   COUNT_ONE = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH-1:0] PTR_ONE   = {{(DEPTH-1){1'b0}}, 1'b1};

  fifo_state_e      state;
  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic [DEPTH:0]   mem_count;
  logic             rd_issue;
  logic             wr_fire;

  // Reads own the port; gating with rst keeps the RAM idle while reset is held.
  assign rd_issue = !rst && (state == ST_IDLE) && (mem_count != '0) && (!rd_valid || rd_ready);
  assign wr_ready = !rst && !rd_issue && (mem_count != MEM_FULL);
  assign wr_fire  = wr_valid && wr_ready;

  assign ram_enable  = rd_issue || wr_fire;
  assign ram_wr_en   = wr_fire;
  assign ram_address = rd_issue ? rd_ptr : wr_ptr;
  assign ram_data_in = wr_data;

  assign level = {1'b0, mem_count}
               + {{(DEPTH+1){1'b0}}, (state == ST_RD_WAIT)}
               + {{(DEPTH+1){1'b0}}, rd_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (wr_fire)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_issue)
        rd_ptr <= rd_ptr + PTR_ONE;

      case ({wr_fire, rd_issue})
        2'b10:   mem_count <= mem_count + COUNT_ONE;
        2'b01:   mem_count <= mem_count - COUNT_ONE;
        default: mem_count <= mem_count;
      endcase

      if (rd_valid && rd_ready)
        rd_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rd_issue)
            state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // refill wins over a same-cycle consume
          rd_data  <= ram_data_out;
          rd_valid <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RAM_FIFO_WATERMARK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      max_level <= '0;
    else if (level > max_level)
      max_level <= level;
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl (DEPTH=2, WIDTH=8) with a behavioural single-port RAM.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 2;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic [DEPTH+1:0] level;
  logic             ram_enable;
  logic             ram_wr_en;
  logic [DEPTH-1:0] ram_address;
  logic [WIDTH-1:0] ram_data_in;
  logic [WIDTH-1:0] ram_data_out;
`ifdef RAM_FIFO_WATERMARK_EN
  logic [DEPTH+1:0] max_level;
`endif

  ram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .level        (level),
    .ram_enable   (ram_enable),
    .ram_wr_en    (ram_wr_en),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
`ifdef RAM_FIFO_WATERMARK_EN
    ,
    .max_level    (max_level)
`endif
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_wr_en) mem[ram_address] <= ram_data_in;
      else           ram_data_out     <= mem[ram_address];
    end
  end

  logic [WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  bit stream_phase = 1'b0;
  bit quiet_phase  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: accepted writes feed the scoreboard, consumed words are checked against it.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
      if (rd_valid && rd_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %0h, expected no word (t=%0t)", rd_data, $time);
        end else begin
          chk("rd_data", rd_data, exp_q.pop_front());
        end
      end
      if (stream_phase) chk("wr_ready_vs_rd_issue", wr_ready, !(ram_enable && !ram_wr_en));
      if (quiet_phase) begin
        chk("idle_ram_enable", ram_enable, 0);
        chk("idle_rd_valid", rd_valid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    logic acc;
    acc = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    if (!acc) chk("write_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_valid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;

    // reset, with a write offered to show the port stays idle
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    repeat (3) tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ram_enable", ram_enable, 0);
    wr_valid = 1'b0;
    rst = 1'b0;
    tick();

    // 1: fill with consumer stalled
    rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) write_word(WIDTH'(8'h11 * i));
    wr_valid = 1'b1;
    wr_data  = 8'h66;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_wr_ready", wr_ready, 0);
      tick();
    end
    @(negedge clk);
    chk("full_level", level, 5);
    chk("full_rd_valid", rd_valid, 1);
    chk("full_rd_data_held", rd_data, 8'h11);
    tick();
    wr_valid = 1'b0;

    // 2: drain in order
    base = n_out;
    rd_ready = 1'b1;
    wait_drain(60);
    repeat (2) tick();
    chk("drain_count", n_out - base, 5);
    chk("drain_rd_valid", rd_valid, 0);
    chk("drain_level", level, 0);

    // 3: empty and idle
    quiet_phase = 1'b1;
    repeat (10) tick();
    quiet_phase = 1'b0;

    // 4: streaming through pointer wrap
    base = n_out;
    stream_phase = 1'b1;
    for (int i = 0; i < 16; i++) write_word(WIDTH'(i));
    wait_drain(60);
    repeat (2) tick();
    stream_phase = 1'b0;
    chk("stream_count", n_out - base, 16);
    chk("stream_level", level, 0);

    // 5: reset while a read is in flight
    rd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) write_word(WIDTH'(8'hC0 + i));
    repeat (4) tick();
    chk("pre_rst_level4", level, 4);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("pre_rst_level3", level, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_ram_enable", ram_enable, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_wr_ready", wr_ready, 1);
    base = n_out;
    rd_ready = 1'b1;
    write_word(8'hA5);
    wait_drain(30);
    repeat (4) tick();
    chk("post_rst_count", n_out - base, 1);

`ifdef RAM_FIFO_WATERMARK_EN
    // 6: watermark tracks peak level, cleared only by reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("wm_after_rst", max_level, 0);
    rd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) write_word(WIDTH'(8'h30 + i));
    repeat (4) tick();
    chk("wm_fill_level", level, 4);
    rd_ready = 1'b1;
    wait_drain(40);
    repeat (2) tick();
    chk("wm_drained_level", level, 0);
    chk("wm_max_level", max_level, 4);
    rst = 1'b1;
    #1;
    chk("wm_rst_clear", max_level, 0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
